// File: rtl/io_uart_tx_port_pkg.sv
// rtl/io_uart_tx_port_pkg.sv - shared constants and types for the RISC0 UART transmit port
package io_uart_tx_port_pkg;

    // I/O word-address map
    localparam logic [3:0] UART_TX_BASE    = 4'd4;
    localparam int         UART_BIT_CYCLES = 217;
    localparam int         UART_DEPTH_LOG2 = 4;

    // STATUS read bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 4;

    // STATUS write control bits
    localparam int CTL_FLUSH   = 0;
    localparam int CTL_CLR_OVF = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic tx_busy(input tx_state_e s);
        return s != TX_IDLE;
    endfunction

endpackage

// File: rtl/io_uart_tx_port_if.sv
// rtl/io_uart_tx_port_if.sv - RISC0 I/O-bus responder interface
interface io_uart_tx_port_if;
    logic        iord;
    logic        iowr;
    logic [5:0]  ioadr;
    logic [31:0] outbus;
    logic [31:0] rdata;
    logic        sel;

    modport master (
        output iord, iowr, ioadr, outbus,
        input  rdata, sel
    );

    modport slave (
        input  iord, iowr, ioadr, outbus,
        output rdata, sel
    );
endinterface

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - synchronous byte FIFO with push/pop/flush and occupancy count
module io_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CAP     = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CAP);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/io_uart_tx_port.sv
// rtl/io_uart_tx_port.sv - buffered 8N1 serial transmit port on the RISC0 I/O bus
module io_uart_tx_port
    import io_uart_tx_port_pkg::*;
#(
    parameter logic [3:0] BASE_ADR   = UART_TX_BASE,
    parameter int         BIT_CYCLES = UART_BIT_CYCLES,
    parameter int         DEPTH_LOG2 = UART_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    io_uart_tx_port_if.slave  bus,
    output logic              TxD
);
    localparam int            TW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    logic [3:0]            word_adr;
    logic                  hit_data;
    logic                  hit_status;
    logic                  data_wr;
    logic                  status_wr;
    logic                  flush;
    logic                  clr_ovf;
    logic                  overflow;

    logic [7:0]            fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_pop;

    tx_state_e             state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [2:0]            bit_idx, bit_idx_n;
    logic [7:0]            shreg, shreg_n;
    logic                  txd_n;
    logic                  bit_done;
    logic [31:0]           status;
    logic                  unused_bits;

    assign word_adr   = bus.ioadr[5:2];
    assign hit_data   = (word_adr == BASE_ADR);
    assign hit_status = (word_adr == BASE_ADR + 4'd1);
    assign bus.sel    = hit_data | hit_status;
    assign data_wr    = bus.iowr & hit_data;
    assign status_wr  = bus.iowr & hit_status;
    assign flush      = status_wr & bus.outbus[CTL_FLUSH];
    assign clr_ovf    = status_wr & bus.outbus[CTL_CLR_OVF];

    // Reads have no side effects and only the low byte is transmitted.
    assign unused_bits = ^{bus.iord, bus.outbus[31:8], bus.ioadr[1:0]};

    io_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata (bus.outbus[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            overflow <= 1'b0;
        else if (clr_ovf)
            overflow <= 1'b0;
        else if (data_wr && fifo_full && !fifo_pop && !flush)
            overflow <= 1'b1;
    end

    always_comb begin
        status                            = '0;
        status[ST_FULL]                   = fifo_full;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_BUSY]                   = tx_busy(state);
        status[ST_OVF]                    = overflow;
        status[ST_COUNT +: DEPTH_LOG2+1]  = fifo_count;
    end

    assign bus.rdata = hit_status ? status : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= TX_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            TxD     <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            TxD     <= txd_n;
        end
    end

    assign bit_done = (timer == TIMER_LAST);

    // TxD is loaded with the level of the bit being entered, so it changes exactly on bit boundaries.
    always_comb begin
        state_n   = state;
        timer_n   = '0;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        txd_n     = TxD;
        fifo_pop  = 1'b0;
        if (state != TX_IDLE) timer_n = bit_done ? '0 : timer + TIMER_ONE;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_n   = fifo_head;
                    bit_idx_n = 3'd0;
                    txd_n     = 1'b0;
                    state_n   = TX_START;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    txd_n   = shreg[0];
                    state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = TX_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        txd_n     = shreg[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    txd_n   = 1'b1;
                    state_n = TX_IDLE;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_io_uart_tx_port.sv
// tb/tb_io_uart_tx_port.sv - directed self-checking bench for io_uart_tx_port
module tb_io_uart_tx_port;
    localparam logic [3:0] BASE = 4'd4;
    localparam int         BC   = 4;
    localparam int         DL   = 2;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    int   n_vec  = 0;
    int   n_miss = 0;

    io_uart_tx_port_if bus ();

    io_uart_tx_port #(
        .BASE_ADR   (BASE),
        .BIT_CYCLES (BC),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .TxD (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] w, input logic [31:0] d);
        bus.ioadr  = {w, 2'b00};
        bus.outbus = d;
        bus.iowr   = 1'b1;
        step();
        bus.iowr   = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        bus.ioadr = {BASE + 4'd1, 2'b00};
        bus.iord  = 1'b1;
        #1;
        check(tag, bus.rdata, exp);
        bus.iord  = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] b, input int from, input int to);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int n = from; n < to; n++) begin
            check($sformatf("txd %02h c%0d", b, n), {31'd0, txd}, {31'd0, fr[n / BC]});
            step();
        end
    endtask

    initial begin
        logic [7:0] q[$];
        rst        = 1'b0;
        bus.iord   = 1'b0;
        bus.iowr   = 1'b0;
        bus.ioadr  = 6'd0;
        bus.outbus = 32'd0;
        step();
        step();
        rst = 1'b1;
        #1;

        // reset / idle state and decode
        check("reset txd", {31'd0, txd}, 32'd1);
        check_status("reset status", 32'h2);
        bus.ioadr = 6'd0;
        #1;
        check("sel word0", {31'd0, bus.sel}, 32'd0);
        check("rdata word0", bus.rdata, 32'd0);
        bus.ioadr = {BASE, 2'b00};
        bus.iord  = 1'b1;
        #1;
        check("sel data", {31'd0, bus.sel}, 32'd1);
        check("rdata data", bus.rdata, 32'd0);
        bus.iord  = 1'b0;
        bus.ioadr = {BASE + 4'd2, 2'b00};
        #1;
        check("sel word6", {31'd0, bus.sel}, 32'd0);

        // single byte 0xA5
        wr(BASE, 32'hA5);
        check("a5 txd after push", {31'd0, txd}, 32'd1);
        check_status("a5 status queued", 32'h10);
        step();
        check_status("a5 status busy", 32'h6);
        check_frame(8'hA5, 0, 10 * BC);
        check("a5 idle txd", {31'd0, txd}, 32'd1);
        check_status("a5 status done", 32'h2);

        // six back-to-back writes: fill, overflow, then flush mid frame 2
        wr(BASE, 32'h11);
        wr(BASE, 32'h22);
        wr(BASE, 32'h33);
        wr(BASE, 32'h44);
        wr(BASE, 32'h55);
        check_status("fill full", 32'h45);
        wr(BASE, 32'h66);
        check_status("fill overflow", 32'h4D);
        check_frame(8'h11, 4, 10 * BC);
        check_status("fill idle gap", 32'h49);
        step();
        check_frame(8'h22, 0, 9);
        wr(BASE + 4'd1, 32'h3);
        check_status("flush status", 32'h6);
        check_frame(8'h22, 10, 10 * BC);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("post flush txd %0d", i), {31'd0, txd}, 32'd1);
            step();
        end
        check_status("post flush status", 32'h2);

        // push while full in the same cycle as the FSM pop
        wr(BASE, 32'h3C);
        wr(BASE, 32'h81);
        wr(BASE, 32'h7E);
        wr(BASE, 32'hE1);
        wr(BASE, 32'h18);
        check_status("pp full", 32'h45);
        check_frame(8'h3C, 3, 10 * BC);
        check_status("pp idle full", 32'h41);
        wr(BASE, 32'hC5);
        check_status("pp accepted", 32'h45);
        q = '{8'h81, 8'h7E, 8'hE1, 8'h18, 8'hC5};
        for (int i = 0; i < q.size(); i++) begin
            check_frame(q[i], 0, 10 * BC);
            if (i != q.size() - 1) step();
        end
        check_status("pp drained", 32'h2);

        // reset in the middle of a data bit, with a byte still queued
        wr(BASE, 32'h5A);
        wr(BASE, 32'hC3);
        check_frame(8'h5A, 0, 14);
        check("pre reset txd", {31'd0, txd}, 32'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("post reset txd", {31'd0, txd}, 32'd1);
        check_status("post reset status", 32'h2);
        wr(BASE, 32'h96);
        check("after reset push txd", {31'd0, txd}, 32'd1);
        step();
        check_frame(8'h96, 0, 10 * BC);
        check_status("after reset done", 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
